// File: rtl/mips_defines.sv
// Shared MIPS pipeline constants: register-zero address, scoreboard slot
// state encoding and default scoreboard sizing.
package mips_defines;

  // Architectural register r0 is hard-wired to zero and never has a pending write.
  localparam logic [4:0] ZERO = 5'd0;

  // Scoreboard slot states.
  localparam logic [0:0] SLOT_FREE = 1'b0;
  localparam logic [0:0] SLOT_BUSY = 1'b1;

  // Default scoreboard sizing.
  localparam int DEFAULT_NSLOTS = 4;
  localparam int DEFAULT_LAT_W  = 5;

endpackage

// File: rtl/scoreboard_slot.sv
// One in-flight long-latency write: tracks the destination register and the
// cycles left until its result becomes forwardable.
module scoreboard_slot
  import mips_defines::*;
#(
  parameter int ADDR_W = 5,
  parameter int LAT_W  = DEFAULT_LAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_dst,
  input  logic [LAT_W-1:0]  load_lat,
  input  logic [ADDR_W-1:0] match_addr,
  output logic              busy,
  output logic [ADDR_W-1:0] dst,
  output logic              match
);

  logic [0:0]        state_reg;
  logic [ADDR_W-1:0] dst_reg;
  logic [LAT_W-1:0]  count_reg;

  // Slot FSM: load when allocated, count down while busy, free on 1->0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= SLOT_FREE;
      dst_reg   <= '0;
      count_reg <= '0;
    end else if (flush) begin
      state_reg <= SLOT_FREE;
      count_reg <= '0;
    end else if (load) begin
      state_reg <= SLOT_BUSY;
      dst_reg   <= load_dst;
      count_reg <= load_lat;
    end else if (state_reg == SLOT_BUSY) begin
      count_reg <= count_reg - LAT_W'(1);
      if (count_reg == LAT_W'(1)) begin
        state_reg <= SLOT_FREE;
      end
    end
  end

  assign busy  = (state_reg == SLOT_BUSY);
  assign dst   = dst_reg;
  assign match = busy && (dst_reg == match_addr);

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-write scoreboard for multi-cycle ops (DIVU, MUL): allocates slots,
// blocks WAW re-issue and raises decode stall on RAW hazards or full slots.
module hazard_scoreboard
  import mips_defines::*;
#(
  parameter int NSLOTS = DEFAULT_NSLOTS,
  parameter int LAT_W  = DEFAULT_LAT_W,
  parameter int ADDR_W = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid,
  input  logic [ADDR_W-1:0]           issue_dst,
  input  logic [LAT_W-1:0]            issue_lat,
  output logic                        issue_ready,
  input  logic [ADDR_W-1:0]           rs_addr,
  input  logic [ADDR_W-1:0]           rt_addr,
  input  logic                        read_rs,
  input  logic                        read_rt,
  input  logic                        flush,
  output logic                        stall,
  output logic [2**ADDR_W-1:0]        busy_vec,
  output logic [$clog2(NSLOTS+1)-1:0] inflight
);

  localparam int NREGS = 2**ADDR_W;
  localparam int CNT_W = $clog2(NSLOTS+1);

  logic [NSLOTS-1:0]    slot_busy;
  logic [NSLOTS-1:0]    slot_match;
  logic [NSLOTS-1:0]    slot_load;
  logic [NSLOTS:0]      lower_free;   // bit gi: some slot below gi is free
  logic [ADDR_W-1:0]    slot_dst [NSLOTS];
  logic [NREGS-1:0]     slot_onehot [NSLOTS];
  logic                 null_op;
  logic                 alloc_go;
  logic                 rs_haz;
  logic                 rt_haz;

  assign lower_free[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < NSLOTS; gi++) begin : g_slot
      // Lowest-index free slot wins the allocation.
      assign slot_load[gi]    = alloc_go & ~slot_busy[gi] & ~lower_free[gi];
      assign lower_free[gi+1] = lower_free[gi] | ~slot_busy[gi];
      assign slot_onehot[gi]  = slot_busy[gi] ? (NREGS'(1) << slot_dst[gi]) : '0;

      scoreboard_slot #(
        .ADDR_W (ADDR_W),
        .LAT_W  (LAT_W)
      ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .load       (slot_load[gi]),
        .load_dst   (issue_dst),
        .load_lat   (issue_lat),
        .match_addr (issue_dst),
        .busy       (slot_busy[gi]),
        .dst        (slot_dst[gi]),
        .match      (slot_match[gi])
      );
    end
  endgenerate

  // Pending-write vector and occupancy, from registered slot state only.
  always_comb begin
    busy_vec = '0;
    inflight = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      busy_vec = busy_vec | slot_onehot[i];
      inflight = inflight + CNT_W'(slot_busy[i]);
    end
  end

  // Writes to r0 or with zero latency need no tracking and are always accepted.
  assign null_op     = (issue_dst == ADDR_W'(ZERO)) | (issue_lat == '0);
  assign issue_ready = rst & issue_valid & ~flush &
                       (null_op | (lower_free[NSLOTS] & ~(|slot_match)));
  assign alloc_go    = issue_ready & ~null_op;

  assign rs_haz = read_rs & (rs_addr != ADDR_W'(ZERO)) & busy_vec[rs_addr];
  assign rt_haz = read_rt & (rt_addr != ADDR_W'(ZERO)) & busy_vec[rt_addr];

  // During flush the in-flight writes are being killed, so no stall is needed.
  assign stall = rst & ~flush & (rs_haz | rt_haz | (issue_valid & ~issue_ready));

endmodule
